cmp_window_stats: RTL

CMP_WINDOW_STATS -- requirements
Module: cmp_window_stats

---
 rtl/cmp_pkg.sv | 18 +
 rtl/cmp_core.sv | 38 +++
 rtl/cmp_window_stats.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
// Shared definitions for the cmp_window_stats block.
//   state_t        : window FSM state (ACCUM collects pairs, HOLD presents a
//                    finished summary until downstream takes it)
//   WIDTH_DEFAULT  : default operand width for cmp_core / cmp_window_stats
// Optional feature macro used by the block: CMP_WINDOW_MAXDIFF_EN
// -----------------------------------------------------------------------------
package cmp_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage : cmp_pkg

// File: rtl/cmp_core.sv
// -----------------------------------------------------------------------------
// cmp_core
// Purely combinational unsigned compare of two WIDTH-bit operands.
// Ports:
//   a, b      in   WIDTH  unsigned operands
//   gt        out  1      a > b
//   lt        out  1      a < b
//   eq        out  1      a == b
//   abs_diff  out  WIDTH  |a - b|  (present only with CMP_WINDOW_MAXDIFF_EN)
// Configuration macro: CMP_WINDOW_MAXDIFF_EN adds the subtractor and the
// abs_diff port; without it no subtractor exists in this module.
// -----------------------------------------------------------------------------
module cmp_core
  import cmp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             lt,
  output logic             eq
`ifdef CMP_WINDOW_MAXDIFF_EN
  ,
  output logic [WIDTH-1:0] abs_diff
`endif
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

`ifdef CMP_WINDOW_MAXDIFF_EN
  // Subtract the smaller from the larger so the result never underflows.
  assign abs_diff = gt ? (a - b) : (b - a);
`endif

endmodule : cmp_core

// File: rtl/cmp_window_stats.sv
// -----------------------------------------------------------------------------
// cmp_window_stats
// Compares a stream of operand pairs {a,b} and summarises each window of up to
// WIN pairs: how many had a>b, a<b, a==b, the number of pairs and (optionally)
// the largest |a-b|. A window closes when it reaches WIN pairs or on flush
// (if it holds at least one pair); the summary is then held until out_ready.
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      pair {a,b} valid
//   in_ready   out  1      pair accepted this cycle when in_valid
//   a, b       in   WIDTH  unsigned operands
//   flush      in   1      close the current partial window
//   out_valid  out  1      summary valid
//   out_ready  in   1      downstream takes the summary
//   cnt_gt/lt/eq out CNT_W per-window compare counts
//   n_samples  out  CNT_W  pairs in the window
//   max_diff   out  WIDTH  largest |a-b| in the window, 0 without the macro
// Configuration macro: CMP_WINDOW_MAXDIFF_EN enables max_diff tracking.
// -----------------------------------------------------------------------------
module cmp_window_stats
  import cmp_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEFAULT,
  parameter  int WIN   = 16,
  localparam int CNT_W = $clog2(WIN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt_gt,
  output logic [CNT_W-1:0] cnt_lt,
  output logic [CNT_W-1:0] cnt_eq,
  output logic [CNT_W-1:0] n_samples,
  output logic [WIDTH-1:0] max_diff
);

  localparam logic [CNT_W-1:0] WIN_C = CNT_W'(WIN);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Compare datapath
  // ---------------------------------------------------------------------------
  logic is_gt, is_lt, is_eq;

`ifdef CMP_WINDOW_MAXDIFF_EN
  logic [WIDTH-1:0] abs_diff;
`endif

  cmp_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a        (a),
    .b        (b),
    .gt       (is_gt),
    .lt       (is_lt),
    .eq       (is_eq)
`ifdef CMP_WINDOW_MAXDIFF_EN
    ,
    .abs_diff (abs_diff)
`endif
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_q,     state_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_gt_q,    cnt_gt_d;
  logic [CNT_W-1:0] cnt_lt_q,    cnt_lt_d;
  logic [CNT_W-1:0] cnt_eq_q,    cnt_eq_d;
  logic [CNT_W-1:0] n_q,         n_d;
`ifdef CMP_WINDOW_MAXDIFF_EN
  logic [WIDTH-1:0] max_q,       max_d;
`endif

  logic accept;

  // in_ready_q is 1 exactly in ACCUM, so it doubles as the accept qualifier.
  assign accept = in_valid && in_ready_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every _d gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch; blocking '=' is correct here.
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    cnt_gt_d    = cnt_gt_q;
    cnt_lt_d    = cnt_lt_q;
    cnt_eq_d    = cnt_eq_q;
    n_d         = n_q;
`ifdef CMP_WINDOW_MAXDIFF_EN
    max_d       = max_q;
`endif

    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          if (is_gt) cnt_gt_d = cnt_gt_q + ONE_C;
          if (is_lt) cnt_lt_d = cnt_lt_q + ONE_C;
          if (is_eq) cnt_eq_d = cnt_eq_q + ONE_C;
          n_d = n_q + ONE_C;
`ifdef CMP_WINDOW_MAXDIFF_EN
          if (abs_diff > max_q) max_d = abs_diff;
`endif
        end
        // n_d already includes a same-cycle accept, so a flush arriving with
        // the first pair still closes a one-sample window, and a full window
        // closes without ever letting the count pass WIN.
        if ((n_d == WIN_C) || (flush && (n_d != '0))) begin
          state_d     = HOLD;
          in_ready_d  = 1'b0;
          out_valid_d = 1'b1;
        end
      end

      HOLD: begin
        // Summary is frozen until taken; flush and in_valid have no effect.
        if (out_ready) begin
          state_d     = ACCUM;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          cnt_gt_d    = '0;
          cnt_lt_d    = '0;
          cnt_eq_d    = '0;
          n_d         = '0;
`ifdef CMP_WINDOW_MAXDIFF_EN
          max_d       = '0;
`endif
        end
      end

      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous (sampled only on the clock edge) and takes
    // priority over every other input in the same cycle.
    if (rst) begin
      state_q     <= ACCUM;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cnt_gt_q    <= '0;
      cnt_lt_q    <= '0;
      cnt_eq_q    <= '0;
      n_q         <= '0;
`ifdef CMP_WINDOW_MAXDIFF_EN
      max_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cnt_gt_q    <= cnt_gt_d;
      cnt_lt_q    <= cnt_lt_d;
      cnt_eq_q    <= cnt_eq_d;
      n_q         <= n_d;
`ifdef CMP_WINDOW_MAXDIFF_EN
      max_q       <= max_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all driven straight from registers)
  // ---------------------------------------------------------------------------
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign cnt_gt    = cnt_gt_q;
  assign cnt_lt    = cnt_lt_q;
  assign cnt_eq    = cnt_eq_q;
  assign n_samples = n_q;

`ifdef CMP_WINDOW_MAXDIFF_EN
  assign max_diff = max_q;
`else
  assign max_diff = '0;
`endif

endmodule : cmp_window_stats
